// File: rtl/bitop_pkg.sv
// bitop_pkg: opcode encodings and output-stage state type shared by the
// bitwise-op arbiter and its logic unit.
package bitop_pkg;

  localparam int OP_W = 2;

  // Opcode encoding seen on the requester op ports and echoed on out_op
  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOT = 2'd3
  } op_e;

  // Output register occupancy: EMPTY means out_valid low, FULL means a result is held
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/bitop_unit.sv
// bitop_unit: purely combinational bitwise logic unit (AND/OR/XOR/NOT).
// Operand B is ignored for NOT. There is no carry and no width extension.
module bitop_unit
  import bitop_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  logic [WIDTH-1:0] w_result;

  // Select the bitwise function named by the opcode
  always_comb begin
    w_result = '0;
    case (op_e'(i_op))
      OP_AND:  w_result = i_a & i_b;
      OP_OR:   w_result = i_a | i_b;
      OP_XOR:  w_result = i_a ^ i_b;
      OP_NOT:  w_result = ~i_a;
      default: w_result = '0;
    endcase
  end

  assign o_result = w_result;

endmodule

// File: rtl/bitop_arbiter.sv
// bitop_arbiter: round-robin sharing of one bitop_unit between two
// valid/ready requesters, feeding a single registered output stage.
// The output register reloads in the same cycle it drains, so sustained
// throughput is one result per cycle.
// Optional feature macro BITOP_ARB_CNT_EN: adds saturating 16-bit counters
// cnt0/cnt1 of output handshakes per result tag.
module bitop_arbiter
  import bitop_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_tag,
  output logic [OP_W-1:0]  out_op
`ifdef BITOP_ARB_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  out_state_e       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_tag;
  logic [OP_W-1:0]  r_op;
  logic             r_lastGrant;

  logic             w_load;
  logic             w_grant;
  logic             w_accept;
  logic [OP_W-1:0]  w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;

  // A new result can be loaded when the stage is empty or is draining this cycle
  assign w_load = (r_state == ST_EMPTY) || out_ready;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins
  always_comb begin
    w_grant = ~r_lastGrant;
    if (req0_valid && !req1_valid) begin
      w_grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      w_grant = 1'b1;
    end
  end

  assign req0_ready = w_load && !w_grant && req0_valid;
  assign req1_ready = w_load &&  w_grant && req1_valid;
  assign w_accept   = req0_ready || req1_ready;

  assign w_op = w_grant ? req1_op : req0_op;
  assign w_a  = w_grant ? req1_a  : req0_a;
  assign w_b  = w_grant ? req1_b  : req0_b;

  bitop_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .i_op     (w_op),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_result)
  );

  // Output-stage FSM with registered result fields and the round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_data      <= '0;
      r_tag       <= 1'b0;
      r_op        <= '0;
      r_lastGrant <= 1'b1;
    end else begin
      if (w_accept) begin
        r_data      <= w_result;
        r_tag       <= w_grant;
        r_op        <= w_op;
        r_lastGrant <= w_grant;
      end
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_FULL;
        ST_FULL:  if (out_ready && !w_accept) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_tag   = r_tag;
  assign out_op    = r_op;

`ifdef BITOP_ARB_CNT_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;
  logic        w_handshake;

  assign w_handshake = out_valid && out_ready;

  // Count delivered results per tag, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_handshake) begin
      if (!r_tag && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
      if ( r_tag && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_bitop_arbiter.sv
// tb_bitop_arbiter: scoreboard bench for bitop_arbiter (WIDTH=3).
// The driver predicts grants and results from the round-robin rules and
// queues expected results; the monitor compares whatever the DUT presents.
module tb_bitop_arbiter;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         out_valid, out_ready, out_tag;
  logic [W-1:0] out_data;
  logic [1:0]   out_op;
`ifdef BITOP_ARB_CNT_EN
  logic [15:0]  cnt0, cnt1;
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic         tag;
    logic [1:0]   op;
  } exp_t;

  exp_t        expQ[$];
  int          testsRun    = 0;
  int          testsFailed = 0;
  logic        modelFull;
  logic        modelLast;
  int unsigned expCnt0, expCnt1;
  logic        pend0, pend1;
  logic [1:0]  h0op, h1op;
  logic [W-1:0] h0a, h0b, h1a, h1b;

  bitop_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_op     (out_op)
`ifdef BITOP_ARB_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference bitwise operation straight from the opcode table
  function automatic logic [W-1:0] refOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Hold reset for one edge, then check the cleared outputs and reset the model
  task automatic applyReset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expQ.delete();
    modelFull = 1'b0;
    modelLast = 1'b1;
    expCnt0   = 0;
    expCnt1   = 0;
    pend0     = 1'b0;
    pend1     = 1'b0;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_data",  {29'd0, out_data},  32'd0);
    checkOutput("reset_out_tag",   {31'd0, out_tag},   32'd0);
    checkOutput("reset_out_op",    {30'd0, out_op},    32'd0);
  endtask

  // Drive one cycle of inputs, predict grant/readiness, queue any expected result
  task automatic applyStimulus(
    input logic v0, input logic [1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
    input logic v1, input logic [1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
    input logic ordy);
    logic load, win, acc;
    rst_n      = 1'b1;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    out_ready  = ordy;
    #2;
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, modelFull});
    load = !modelFull || ordy;
    if (v0 && v1) win = !modelLast;
    else          win = v1;
    acc = load && (v0 || v1);
    checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, acc && !win});
    checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, acc && win});
    if (acc) begin
      if (win) expQ.push_back('{data: refOp(op1, a1, b1), tag: 1'b1, op: op1});
      else     expQ.push_back('{data: refOp(op0, a0, b0), tag: 1'b0, op: op0});
      modelLast = win;
      modelFull = 1'b1;
    end else if (ordy) begin
      modelFull = 1'b0;
    end
    pend0 = v0 && !(acc && !win);
    pend1 = v1 && !(acc && win);
    h0op = op0; h0a = a0; h0b = b0;
    h1op = op1; h1a = a1; h1b = b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented result against the queue head, pop on handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", {31'd0, out_valid}, 32'd0);
      end else begin
        checkOutput("out_data", {29'd0, out_data}, {29'd0, expQ[0].data});
        checkOutput("out_tag",  {31'd0, out_tag},  {31'd0, expQ[0].tag});
        checkOutput("out_op",   {30'd0, out_op},   {30'd0, expQ[0].op});
        if (out_ready === 1'b1) begin
          if (expQ[0].tag) begin
            if (expCnt1 < 32'hFFFF) expCnt1++;
          end else begin
            if (expCnt0 < 32'hFFFF) expCnt0++;
          end
          void'(expQ.pop_front());
        end
      end
    end
  end

  // Main sequence: directed scenarios, randomized traffic, then drain
  initial begin
    logic v0, v1, ordy;
    logic [1:0] o0, o1;
    logic [W-1:0] a0, b0, a1, b1;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    applyReset();

    // Reset while a result is held and stalled, then the first tie goes to req0
    applyStimulus(1'b1, 2'd0, 3'b111, 3'b111, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0);
    applyStimulus(1'b0, 2'd0, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0);
    applyReset();
    applyStimulus(1'b1, 2'd1, 3'b100, 3'b001, 1'b1, 2'd2, 3'b111, 3'b010, 1'b1);
    applyStimulus(1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 2'd2, 3'b111, 3'b010, 1'b1);

    // AND 101 & 011 from req0
    applyStimulus(1'b1, 2'd0, 3'b101, 3'b011, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1);
    // NOT 010 from req1, then XOR 110 ^ 011 from req0
    applyStimulus(1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 2'd3, 3'b010, 3'b111, 1'b1);
    applyStimulus(1'b1, 2'd2, 3'b110, 3'b011, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1);

    // Sustained tie traffic alternates tags at one result per cycle
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom),
                    1'b1, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 1'b1);
    end

    // Stall a full stage for three cycles with both requesters waiting, then release
    applyStimulus(1'b1, 2'd1, 3'b001, 3'b100, 1'b1, 2'd0, 3'b110, 3'b011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd1, 3'b001, 3'b100, 1'b1, 2'd0, 3'b110, 3'b011, 1'b0);
    end
    applyStimulus(1'b1, 2'd1, 3'b001, 3'b100, 1'b1, 2'd0, 3'b110, 3'b011, 1'b1);
    applyStimulus(1'b1, 2'd1, 3'b001, 3'b100, 1'b1, 2'd0, 3'b110, 3'b011, 1'b1);

    // Random traffic; a requester left waiting keeps its command stable
    for (int i = 0; i < 400; i++) begin
      v0 = pend0 ? 1'b1 : 1'($urandom_range(0, 1));
      o0 = pend0 ? h0op : 2'($urandom_range(0, 3));
      a0 = pend0 ? h0a  : 3'($urandom);
      b0 = pend0 ? h0b  : 3'($urandom);
      v1 = pend1 ? 1'b1 : 1'($urandom_range(0, 1));
      o1 = pend1 ? h1op : 2'($urandom_range(0, 3));
      a1 = pend1 ? h1a  : 3'($urandom);
      b1 = pend1 ? h1b  : 3'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      applyStimulus(v0, o0, a0, b0, v1, o1, a1, b1, ordy);
    end

    // Drain whatever remains and confirm nothing is left outstanding
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1);
    end
    checkOutput("queue_drained", expQ.size(), 32'd0);

`ifdef BITOP_ARB_CNT_EN
    // Counters: a few req1 results, then enough req0 results to saturate cnt0
    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 2'd2, 3'($urandom), 3'($urandom), 1'b1);
    end
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom),
                    1'b0, 2'd0, 3'b000, 3'b000, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 2'd0, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1);
    end
    checkOutput("cnt0_model", {16'd0, cnt0}, expCnt0);
    checkOutput("cnt0_saturated", {16'd0, cnt0}, 32'h0000FFFF);
    checkOutput("cnt1_unaffected", {16'd0, cnt1}, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
